keypad_color_bank: RTL

Scans a 4x4 matrix keypad, debounces presses and keeps a 16-entry bank of 3-bit RGB111 colour indices, one per keypad key / screen rectangle. Each confirmed press advances that key's colour index by one (mod 8). It sits directly upstream of the VGA rectangle renderer, which drives `posicion` and reads back `dirColor` as the colour-memory address for the rectangle being drawn.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_color_bank_sync_2ff.sv | 23 ++
 rtl/keypad_color_bank.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad colour bank.
// Holds the scan FSM state enum, bank geometry and the key-to-position map.
// Positions run top-left = 15 down to bottom-right = 0, matching the renderer.
package keypad_pkg;

   localparam int POS_W    = 4;
   localparam int COLOR_W  = 3;
   localparam int NUM_KEYS = 16;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   // Column c (0 = leftmost), row r (0 = top) -> screen rectangle index.
   function automatic logic [POS_W-1:0] key_to_pos(input logic [1:0] c,
                                                   input logic [1:0] r);
      return 4'd15 - {c, 2'b00} - {2'b00, r};
   endfunction

endpackage

// File: rtl/keypad_color_bank_sync_2ff.sv
// sync_2ff: 4-bit two-flop synchroniser for the keypad row lines.
// Ports: clk, rst (async, active-high), d (asynchronous input), q (synchronised).
// Flops reset to all ones, i.e. "no key pressed" on the pulled-up rows.
module sync_2ff (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 4'hF;
         q    <= 4'hF;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_color_bank.sv
// keypad_color_bank: scans a 4x4 keypad, debounces presses and bumps a per-key
// 3-bit colour index. Ports: clk, rst, fil (rows), col (one-cold columns),
// posicion/dirColor (combinational bank read), key_valid/key_pos (press event).
// Optional macro KEYPAD_RESET_PATTERN_EN: reset loads bank[i] = i[2:0] instead of 0.
module keypad_color_bank
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int DEB_CYCLES = 500000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         fil,
   output logic [3:0]         col,
   input  logic [POS_W-1:0]   posicion,
   output logic [COLOR_W-1:0] dirColor,
   output logic               key_valid,
   output logic [POS_W-1:0]   key_pos
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);

   logic [3:0]         fil_s;
   state_t             state, state_nxt;
   logic [1:0]         col_idx, col_nxt;
   logic [1:0]         row_idx, row_nxt;
   logic [DW-1:0]      dwell, dwell_nxt;
   logic [CW-1:0]      cnt, cnt_nxt;
   logic               wr_en;
   logic [1:0]         first_low;
   logic               row_lvl;
   logic [POS_W-1:0]   wr_pos;
   logic [COLOR_W-1:0] bank [NUM_KEYS];

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (fil),
      .q   (fil_s)
   );

   // Lowest-indexed low row wins when several rows read pressed.
   always_comb begin
      first_low = 2'd3;
      if      (!fil_s[0]) first_low = 2'd0;
      else if (!fil_s[1]) first_low = 2'd1;
      else if (!fil_s[2]) first_low = 2'd2;
   end

   assign row_lvl = fil_s[row_idx];
   assign wr_pos  = key_to_pos(col_idx, row_idx);
   assign col     = ~(4'b0001 << col_idx);

   always_comb begin
      state_nxt = state;
      col_nxt   = col_idx;
      row_nxt   = row_idx;
      dwell_nxt = dwell;
      cnt_nxt   = cnt;
      wr_en     = 1'b0;
      case (state)
         SCAN: begin
            // Rows are only sampled on the last dwell cycle so the
            // synchroniser has flushed the previous column's levels.
            if (dwell == DWELL_LAST) begin
               dwell_nxt = '0;
               if (fil_s != 4'hF) begin
                  row_nxt   = first_low;
                  cnt_nxt   = '0;
                  state_nxt = DEBOUNCE;
               end else begin
                  col_nxt = col_idx + 2'd1;
               end
            end else begin
               dwell_nxt = dwell + DW'(1);
            end
         end
         DEBOUNCE: begin
            if (row_lvl) begin
               state_nxt = SCAN;
               col_nxt   = col_idx + 2'd1;
               cnt_nxt   = '0;
            end else if (cnt == DEB_LAST) begin
               wr_en     = 1'b1;
               cnt_nxt   = '0;
               state_nxt = HELD;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         HELD: begin
            if (row_lvl) begin
               state_nxt = RELEASE;
               cnt_nxt   = '0;
            end
         end
         RELEASE: begin
            if (!row_lvl) begin
               state_nxt = HELD;
               cnt_nxt   = '0;
            end else if (cnt == DEB_LAST) begin
               state_nxt = SCAN;
               col_nxt   = col_idx + 2'd1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = SCAN;
            cnt_nxt   = '0;
            dwell_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         col_idx   <= 2'd0;
         row_idx   <= 2'd0;
         dwell     <= '0;
         cnt       <= '0;
         key_valid <= 1'b0;
         key_pos   <= '0;
      end else begin
         state     <= state_nxt;
         col_idx   <= col_nxt;
         row_idx   <= row_nxt;
         dwell     <= dwell_nxt;
         cnt       <= cnt_nxt;
         key_valid <= wr_en;
         if (wr_en) key_pos <= wr_pos;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_KEYS; i++) begin
`ifdef KEYPAD_RESET_PATTERN_EN
            bank[i] <= COLOR_W'(i);
`else
            bank[i] <= '0;
`endif
         end
      end else if (wr_en) begin
         bank[wr_pos] <= bank[wr_pos] + COLOR_W'(1);
      end
   end

   assign dirColor = bank[posicion];

endmodule
